ssd_scan_driver: RTL

Time-multiplexed scan driver for the 4-digit common-anode seven-segment display. Consumes the packed 32-bit active-low segment word produced by the number-to-segment encoder, holds it in a shadow register so a frame never tears, and drives one digit at a time with a blanking gap against ghosting. Sits between the encoder and the board pins.

---
 rtl/ssd_scan_driver.sv | 128 ++++++++++++
 1 files changed

// File: rtl/ssd_scan_driver.sv
// ssd_scan_driver
// Time-multiplexed scan driver for a 4-digit common-anode seven-segment
// display. A loaded segment word is held in a shadow register and only
// promoted to the displayed word on a frame boundary, so a frame never
// shows a mix of old and new digits. Each digit slot begins with a short
// all-anodes-off gap to suppress ghosting.
//
// Optional feature: define SSD_DIM_EN to enable PWM dimming via dim_level.
//
// Ports:
//   clk         system clock
//   rst_n       asynchronous active-low reset
//   seg_word    packed active-low pattern, [31:24] = digit 3 .. [7:0] = digit 0,
//               per byte bit7..bit1 = g..a, bit0 = dp
//   load        single-cycle strobe capturing seg_word
//   blank       level, forces all anodes off
//   dim_level   brightness 0 (dimmest) .. 3 (full), used only with SSD_DIM_EN
//   an          anode enables, active-low
//   seg         {g,f,e,d,c,b,a}, active-low
//   dp          decimal point, active-low
//   pending     a loaded word is waiting for the frame boundary
//   frame_done  one-cycle pulse per completed 4-digit scan
module ssd_scan_driver #(
    parameter int DIGIT_TICKS = 100000,
    parameter int BLANK_TICKS = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] seg_word,
    input  logic        load,
    input  logic        blank,
    input  logic [1:0]  dim_level,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic        pending,
    output logic        frame_done
);

    localparam int TW = (DIGIT_TICKS > 1) ? $clog2(DIGIT_TICKS) : 1;
    localparam logic [TW-1:0] TICK_LAST  = TW'(DIGIT_TICKS - 1);
    localparam logic [TW-1:0] TICK_BLANK = TW'(BLANK_TICKS);

    logic [TW-1:0] tick;
    logic [1:0]    digit;
    logic [31:0]   active_word;
    logic [31:0]   pending_word;
    logic          slot_end;
    logic          boundary;
    logic          dim_ok;
    logic          en;
    logic [7:0]    cur_byte;

`ifdef SSD_DIM_EN
    localparam logic [TW-1:0] SPAN = TW'(DIGIT_TICKS - BLANK_TICKS);
    logic [TW-1:0] on_ticks;

    // On-time window after the blanking gap: SPAN scaled by 1, 1/2, 1/4, 1/8.
    // The subtraction may wrap during the gap, but en is gated by the
    // tick >= TICK_BLANK term in that case anyway.
    always_comb begin
        on_ticks = SPAN >> (2'd3 - dim_level);
        dim_ok   = (tick - TICK_BLANK) < on_ticks;
    end
`else
    logic unused_dim;

    assign dim_ok     = 1'b1;
    assign unused_dim = ^dim_level;
`endif

    always_comb begin
        slot_end = (tick == TICK_LAST);
        boundary = slot_end && (digit == 2'd3);
        en       = (tick >= TICK_BLANK) && !blank && dim_ok;
        cur_byte = active_word[{digit, 3'b000} +: 8];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick         <= '0;
            digit        <= '0;
            active_word  <= '1;
            pending_word <= '1;
            pending      <= 1'b0;
            frame_done   <= 1'b0;
            an           <= '1;
            seg          <= '1;
            dp           <= 1'b1;
        end else begin
            if (slot_end) begin
                tick  <= '0;
                digit <= digit + 2'd1;
            end else begin
                tick <= tick + 1'b1;
            end

            // A load coinciding with the boundary bypasses the shadow and
            // drops any older pending word.
            if (boundary) begin
                frame_done <= 1'b1;
                pending    <= 1'b0;
                if (load) begin
                    active_word <= seg_word;
                end else if (pending) begin
                    active_word <= pending_word;
                end
            end else begin
                frame_done <= 1'b0;
                if (load) begin
                    pending_word <= seg_word;
                    pending      <= 1'b1;
                end
            end

            if (en) begin
                an  <= ~(4'b0001 << digit);
                seg <= cur_byte[7:1];
                dp  <= cur_byte[0];
            end else begin
                an  <= '1;
                seg <= '1;
                dp  <= 1'b1;
            end
        end
    end

endmodule
